apb_timer: RTL and testbench

APB_TIMER -- requirements
Module: apb_timer

---
 rtl/apb_timer.sv | 259 +++++++++++++++++++++++++
 tb/tb_apb_timer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer.sv
// ---------------------------------------------------------------------------
// apb_timer
//   APB slave holding a 32-bit up-counting timer with a compare register,
//   a sticky MATCH status flag and a level interrupt. Every transfer gets one
//   wait state; malformed addresses answer with perr and touch nothing.
//
//   Register map (offset bits [3:2]):
//     0x0 CTRL    [0] EN, [1] AUTORELOAD, [2] IEN, [15:8] PRESC
//     0x4 COUNT   32-bit up counter
//     0x8 COMPARE 32-bit compare value
//     0xC STATUS  [0] MATCH, write-1-to-clear
//
//   Optional feature macro: APB_TIMER_PRESCALE_EN
//     defined   : CTRL[15:8] drives an 8-bit prescaler, one tick every PRESC+1
//                 cycles while EN=1
//     undefined : CTRL[15:8] reads 0, tick follows EN every cycle
//
//   Ports:
//     clk      in   system clock, rising edge
//     rts      in   asynchronous active-low reset
//     paddr    in   APB address, offset bits [11:0] decoded
//     pdata    in   APB write data
//     prdata   out  APB read data, zero unless a read is completing
//     psel     in   slave select
//     penable  in   APB access phase
//     pwrite   in   1 = write, 0 = read
//     pstb     in   byte write strobes, bit n covers byte n
//     pready   out  transfer complete (second access cycle)
//     perr     out  slave error, valid with pready
//     irq      out  registered MATCH & IEN
//
//   The register file is 32 bits wide; DATA_WIDTH is expected to stay 32.
// ---------------------------------------------------------------------------
module apb_timer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rts,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pdata,
    output logic [DATA_WIDTH-1:0] prdata,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [3:0]            pstb,
    output logic                  pready,
    output logic                  perr,
    output logic                  irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic        w_ready;

    logic        r_en;
    logic        r_autoReload;
    logic        r_ien;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_match;
    logic        r_irq;

    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic        w_addrErr;
    logic        w_wrEn;
    logic        w_rdEn;
    logic        w_wrCtrl;
    logic        w_wrCount;
    logic        w_wrCompare;
    logic        w_wrStatus;
    logic        w_tick;
    logic        w_match;
    logic [7:0]  w_presc;
    logic        w_unusedAddr;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = oldVal;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = newVal[8*i +: 8];
            end
        end
        return merged;
    endfunction

    assign w_wdata      = pdata[31:0];
    assign w_unusedAddr = ^paddr[ADDR_WIDTH-1:12];

    // Only word-aligned offsets 0x0..0xC are legal.
    assign w_addrErr = (paddr[1:0] != 2'b00) || (paddr[11:4] != 8'h00);

    // Handshake state register.
    always_ff @(posedge clk or negedge rts) begin
        if (!rts) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Handshake next state: the first access cycle moves to WAIT, the second
    // completes with pready, and DONE absorbs the cycle where the master
    // drops penable. Losing psel in WAIT abandons the transfer.
    always_comb begin
        w_stateNext = r_state;
        w_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (psel && penable) begin
                    w_stateNext = S_WAIT;
                end
            end
            S_WAIT: begin
                if (psel && penable) begin
                    w_ready     = 1'b1;
                    w_stateNext = S_DONE;
                end else begin
                    w_stateNext = S_IDLE;
                end
            end
            S_DONE: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    assign w_wrEn      = w_ready && pwrite && !w_addrErr;
    assign w_rdEn      = w_ready && !pwrite && !w_addrErr;
    assign w_wrCtrl    = w_wrEn && (paddr[3:2] == 2'd0);
    assign w_wrCount   = w_wrEn && (paddr[3:2] == 2'd1);
    assign w_wrCompare = w_wrEn && (paddr[3:2] == 2'd2);
    assign w_wrStatus  = w_wrEn && (paddr[3:2] == 2'd3);

    // Control bits live in byte 0.
    always_ff @(posedge clk or negedge rts) begin
        if (!rts) begin
            r_en         <= 1'b0;
            r_autoReload <= 1'b0;
            r_ien        <= 1'b0;
        end else if (w_wrCtrl && pstb[0]) begin
            r_en         <= w_wdata[0];
            r_autoReload <= w_wdata[1];
            r_ien        <= w_wdata[2];
        end
    end

`ifdef APB_TIMER_PRESCALE_EN
    logic [7:0] r_presc;
    logic [7:0] r_prescCnt;

    // Prescale divisor lives in byte 1.
    always_ff @(posedge clk or negedge rts) begin
        if (!rts) begin
            r_presc <= 8'h00;
        end else if (w_wrCtrl && pstb[1]) begin
            r_presc <= w_wdata[15:8];
        end
    end

    // The prescaler restarts from 0 on any CTRL write so the first tick lands
    // on the cycle right after EN is committed.
    always_ff @(posedge clk or negedge rts) begin
        if (!rts) begin
            r_prescCnt <= 8'h00;
        end else if (!r_en || w_wrCtrl) begin
            r_prescCnt <= 8'h00;
        end else if (r_prescCnt == r_presc) begin
            r_prescCnt <= 8'h00;
        end else begin
            r_prescCnt <= r_prescCnt + 8'd1;
        end
    end

    assign w_presc = r_presc;
    assign w_tick  = r_en && (r_prescCnt == 8'h00);
`else
    assign w_presc = 8'h00;
    assign w_tick  = r_en;
`endif

    // Match compares the value the counter holds before this tick's update.
    assign w_match = w_tick && (r_count == r_compare);

    // A bus write to COUNT beats both increment and auto-reload.
    always_ff @(posedge clk or negedge rts) begin
        if (!rts) begin
            r_count <= 32'h0;
        end else if (w_wrCount) begin
            r_count <= mergeBytes(r_count, w_wdata, pstb);
        end else if (w_tick) begin
            if (w_match && r_autoReload) begin
                r_count <= 32'h0;
            end else begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    // Compare register, byte-lane writable.
    always_ff @(posedge clk or negedge rts) begin
        if (!rts) begin
            r_compare <= 32'h0;
        end else if (w_wrCompare) begin
            r_compare <= mergeBytes(r_compare, w_wdata, pstb);
        end
    end

    // A new match wins over a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge rts) begin
        if (!rts) begin
            r_match <= 1'b0;
        end else if (w_match) begin
            r_match <= 1'b1;
        end else if (w_wrStatus && pstb[0] && w_wdata[0]) begin
            r_match <= 1'b0;
        end
    end

    // Interrupt follows MATCH & IEN one cycle late.
    always_ff @(posedge clk or negedge rts) begin
        if (!rts) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_match && r_ien;
        end
    end

    // Read mux with reserved bits tied to zero.
    always_comb begin
        w_rdata = 32'h0;
        case (paddr[3:2])
            2'd0:    w_rdata = {16'h0, w_presc, 5'h0, r_ien, r_autoReload, r_en};
            2'd1:    w_rdata = r_count;
            2'd2:    w_rdata = r_compare;
            default: w_rdata = {31'h0, r_match};
        endcase
    end

    assign prdata = w_rdEn ? DATA_WIDTH'(w_rdata) : '0;
    assign pready = w_ready;
    assign perr   = w_ready && w_addrErr;
    assign irq    = r_irq;

endmodule

// File: tb/tb_apb_timer.sv
// ---------------------------------------------------------------------------
// tb_apb_timer
//   Directed bench for apb_timer. Each APB transfer queues the response it
//   should produce; a monitor pops that entry whenever pready rises and
//   compares prdata/perr. Interrupt and reset behaviour are checked inline.
//   Compile with APB_TIMER_PRESCALE_EN to switch to the prescaler
//   expectations.
// ---------------------------------------------------------------------------
module tb_apb_timer;

    logic        clk = 1'b0;
    logic        rts;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic [31:0] prdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  pstb;
    logic        pready;
    logic        perr;
    logic        irq;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        string       name;
    } expect_t;

    expect_t expQueue[$];

    apb_timer #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk    (clk),
        .rts    (rts),
        .paddr  (paddr),
        .pdata  (pdata),
        .prdata (prdata),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .pstb   (pstb),
        .pready (pready),
        .perr   (perr),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // Single comparison point shared by every check in the bench.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // One complete APB transfer; the expected response is queued first and the
    // wait-state latency (pready on the second access cycle) is checked here.
    task automatic applyStimulus(input string name, input logic wr,
                                 input logic [11:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input logic [31:0] expRd,
                                 input logic expErr);
        expect_t e;
        int      cycles;
        e.data = expRd;
        e.err  = expErr;
        e.name = name;
        expQueue.push_back(e);
        @(posedge clk);
        #1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = {20'h0, addr};
        pdata   = data;
        pstb    = strb;
        @(posedge clk);
        #1;
        penable = 1'b1;
        cycles  = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (pready !== 1'b1 && cycles < 4);
        checkOutput({name, "_latency"}, cycles, 32'd2);
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        pstb    = 4'h0;
    endtask

    // Scoreboard monitor: every completed transfer consumes one expectation.
    always @(negedge clk) begin
        expect_t e;
        if (pready === 1'b1) begin
            if (expQueue.size() == 0) begin
                checkOutput("unexpected_pready", {31'h0, pready}, 32'h0);
            end else begin
                e = expQueue.pop_front();
                checkOutput({e.name, "_prdata"}, prdata, e.data);
                checkOutput({e.name, "_perr"}, {31'h0, perr}, {31'h0, e.err});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        errorCount++;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence with hand-computed expectations.
    initial begin
        rts     = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pdata   = 32'h0;
        pstb    = 4'h0;
        #12;
        checkOutput("rst_pready", {31'h0, pready}, 32'h0);
        checkOutput("rst_perr",   {31'h0, perr},   32'h0);
        checkOutput("rst_prdata", prdata,          32'h0);
        checkOutput("rst_irq",    {31'h0, irq},    32'h0);
        @(negedge clk);
        rts = 1'b1;

        applyStimulus("rd_status_rst", 1'b0, 12'h00C, 32'h0, 4'h0, 32'h0, 1'b0);
        applyStimulus("rd_ctrl_rst",   1'b0, 12'h000, 32'h0, 4'h0, 32'h0, 1'b0);

        // Auto-reload match at COUNT==5.
        applyStimulus("wr_cmp5",   1'b1, 12'h008, 32'h5, 4'hF, 32'h0, 1'b0);
        applyStimulus("rd_cmp5",   1'b0, 12'h008, 32'h0, 4'h0, 32'h5, 1'b0);
        applyStimulus("wr_ctrl7",  1'b1, 12'h000, 32'h7, 4'hF, 32'h0, 1'b0);
        // Ticks start right after the commit; the COUNT==5 tick is the 6th,
        // MATCH lands at that edge and irq one edge later (8th low phase).
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            checkOutput($sformatf("irq_match_%0d", n), {31'h0, irq},
                        (n == 8) ? 32'h1 : 32'h0);
        end
        // Five more ticks (count 0..4) run until EN drops, leaving COUNT=5.
        applyStimulus("wr_ctrl6",     1'b1, 12'h000, 32'h6, 4'hF, 32'h0, 1'b0);
        applyStimulus("rd_status_m",  1'b0, 12'h00C, 32'h0, 4'h0, 32'h1, 1'b0);
        applyStimulus("rd_count_ar",  1'b0, 12'h004, 32'h0, 4'h0, 32'h5, 1'b0);
        applyStimulus("rd_ctrl6",     1'b0, 12'h000, 32'h0, 4'h0, 32'h6, 1'b0);
        @(negedge clk);
        checkOutput("irq_held", {31'h0, irq}, 32'h1);
        applyStimulus("w1c_status",   1'b1, 12'h00C, 32'h1, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("irq_lag",   {31'h0, irq}, 32'h1);
        @(negedge clk);
        checkOutput("irq_clear", {31'h0, irq}, 32'h0);
        applyStimulus("rd_status_c",  1'b0, 12'h00C, 32'h0, 4'h0, 32'h0, 1'b0);

        // Wraparound: the read samples COUNT three ticks after EN commits.
        applyStimulus("wr_cmp10",     1'b1, 12'h008, 32'h10, 4'hF, 32'h0, 1'b0);
        applyStimulus("wr_count_top", 1'b1, 12'h004, 32'hFFFF_FFFE, 4'hF, 32'h0, 1'b0);
        applyStimulus("wr_ctrl1",     1'b1, 12'h000, 32'h1, 4'hF, 32'h0, 1'b0);
        applyStimulus("rd_count_wrap",1'b0, 12'h004, 32'h0, 4'h0, 32'h1, 1'b0);
        applyStimulus("wr_ctrl0_a",   1'b1, 12'h000, 32'h0, 4'hF, 32'h0, 1'b0);
        applyStimulus("rd_status_w",  1'b0, 12'h00C, 32'h0, 4'h0, 32'h0, 1'b0);
        applyStimulus("rd_count_w",   1'b0, 12'h004, 32'h0, 4'h0, 32'h6, 1'b0);

        // COUNT write beats the coincident tick; then W1C meets a match.
        applyStimulus("wr_ctrl1_b",   1'b1, 12'h000, 32'h1, 4'hF, 32'h0, 1'b0);
        applyStimulus("wr_count100",  1'b1, 12'h004, 32'h100, 4'hF, 32'h0, 1'b0);
        applyStimulus("rd_count100",  1'b0, 12'h004, 32'h0, 4'h0, 32'h103, 1'b0);
        applyStimulus("wr_countD",    1'b1, 12'h004, 32'hD, 4'hF, 32'h0, 1'b0);
        applyStimulus("w1c_on_match", 1'b1, 12'h00C, 32'h1, 4'hF, 32'h0, 1'b0);
        applyStimulus("wr_ctrl0_b",   1'b1, 12'h000, 32'h0, 4'hF, 32'h0, 1'b0);
        applyStimulus("rd_status_keep",1'b0, 12'h00C, 32'h0, 4'h0, 32'h1, 1'b0);
        applyStimulus("rd_count15",   1'b0, 12'h004, 32'h0, 4'h0, 32'h15, 1'b0);
        applyStimulus("w1c_status2",  1'b1, 12'h00C, 32'h1, 4'hF, 32'h0, 1'b0);
        applyStimulus("rd_status_c2", 1'b0, 12'h00C, 32'h0, 4'h0, 32'h0, 1'b0);

        // Illegal offsets: perr, no state change, prdata 0.
        applyStimulus("err_wr_002",   1'b1, 12'h002, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
        applyStimulus("err_wr_010",   1'b1, 12'h010, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
        applyStimulus("err_wr_018",   1'b1, 12'h018, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
        applyStimulus("err_wr_005",   1'b1, 12'h005, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
        applyStimulus("err_rd_014",   1'b0, 12'h014, 32'h0, 4'h0, 32'h0, 1'b1);
        applyStimulus("err_rd_006",   1'b0, 12'h006, 32'h0, 4'h0, 32'h0, 1'b1);
        applyStimulus("rd_ctrl_err",  1'b0, 12'h000, 32'h0, 4'h0, 32'h0, 1'b0);
        applyStimulus("rd_cmp_err",   1'b0, 12'h008, 32'h0, 4'h0, 32'h10, 1'b0);
        applyStimulus("rd_count_err", 1'b0, 12'h004, 32'h0, 4'h0, 32'h15, 1'b0);

        // Byte strobes and reserved bits.
        applyStimulus("wr_cmp0",      1'b1, 12'h008, 32'h0, 4'hF, 32'h0, 1'b0);
        applyStimulus("wr_cmp_lane1", 1'b1, 12'h008, 32'hAABB_CCDD, 4'h2, 32'h0, 1'b0);
        applyStimulus("rd_cmp_lane1", 1'b0, 12'h008, 32'h0, 4'h0, 32'h0000_CC00, 1'b0);
        applyStimulus("wr_count_l03", 1'b1, 12'h004, 32'h1122_3344, 4'h9, 32'h0, 1'b0);
        applyStimulus("rd_count_l03", 1'b0, 12'h004, 32'h0, 4'h0, 32'h1100_0044, 1'b0);
        applyStimulus("wr_ctrl_rsv",  1'b1, 12'h000, 32'hFFFF_FFF8, 4'hF, 32'h0, 1'b0);
`ifdef APB_TIMER_PRESCALE_EN
        applyStimulus("rd_ctrl_rsv",  1'b0, 12'h000, 32'h0, 4'h0, 32'h0000_FF00, 1'b0);
`else
        applyStimulus("rd_ctrl_rsv",  1'b0, 12'h000, 32'h0, 4'h0, 32'h0, 1'b0);
`endif
        applyStimulus("wr_ctrl0_c",   1'b1, 12'h000, 32'h0, 4'hF, 32'h0, 1'b0);

        // CTRL=0x0301: one tick per 4 cycles with the prescaler, else every cycle.
        applyStimulus("wr_count0",    1'b1, 12'h004, 32'h0, 4'hF, 32'h0, 1'b0);
        applyStimulus("wr_ctrl301",   1'b1, 12'h000, 32'h301, 4'hF, 32'h0, 1'b0);
`ifdef APB_TIMER_PRESCALE_EN
        applyStimulus("rd_count_p1",  1'b0, 12'h004, 32'h0, 4'h0, 32'h1, 1'b0);
        applyStimulus("rd_count_p2",  1'b0, 12'h004, 32'h0, 4'h0, 32'h2, 1'b0);
        applyStimulus("rd_ctrl301",   1'b0, 12'h000, 32'h0, 4'h0, 32'h301, 1'b0);
`else
        applyStimulus("rd_count_p1",  1'b0, 12'h004, 32'h0, 4'h0, 32'h3, 1'b0);
        applyStimulus("rd_count_p2",  1'b0, 12'h004, 32'h0, 4'h0, 32'h7, 1'b0);
        applyStimulus("rd_ctrl301",   1'b0, 12'h000, 32'h0, 4'h0, 32'h1, 1'b0);
`endif
        applyStimulus("wr_ctrl0_d",   1'b1, 12'h000, 32'h0, 4'hF, 32'h0, 1'b0);

        // Raise irq (COUNT==COMPARE==0 on the first tick), then reset mid-transfer.
        applyStimulus("wr_cmp0_b",    1'b1, 12'h008, 32'h0, 4'hF, 32'h0, 1'b0);
        applyStimulus("wr_count0_b",  1'b1, 12'h004, 32'h0, 4'hF, 32'h0, 1'b0);
        applyStimulus("wr_ctrl5",     1'b1, 12'h000, 32'h5, 4'hF, 32'h0, 1'b0);
        applyStimulus("wr_ctrl4",     1'b1, 12'h000, 32'h4, 4'hF, 32'h0, 1'b0);
        applyStimulus("wr_cmp77",     1'b1, 12'h008, 32'h77, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("irq_pre_rst", {31'h0, irq}, 32'h1);

        @(posedge clk);
        #1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0000_000C;
        @(posedge clk);
        #1;
        penable = 1'b1;
        #2;
        rts = 1'b0;
        #1;
        checkOutput("mid_rst_pready", {31'h0, pready}, 32'h0);
        checkOutput("mid_rst_perr",   {31'h0, perr},   32'h0);
        checkOutput("mid_rst_prdata", prdata,          32'h0);
        checkOutput("mid_rst_irq",    {31'h0, irq},    32'h0);
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            checkOutput($sformatf("mid_rst_hold_%0d", n), {31'h0, pready}, 32'h0);
        end
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        rts = 1'b1;

        applyStimulus("rd_ctrl_post",   1'b0, 12'h000, 32'h0, 4'h0, 32'h0, 1'b0);
        applyStimulus("rd_cmp_post",    1'b0, 12'h008, 32'h0, 4'h0, 32'h0, 1'b0);
        applyStimulus("rd_count_post",  1'b0, 12'h004, 32'h0, 4'h0, 32'h0, 1'b0);
        applyStimulus("rd_status_post", 1'b0, 12'h00C, 32'h0, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("irq_post_rst", {31'h0, irq}, 32'h0);

        repeat (2) @(negedge clk);
        checkOutput("queue_empty", expQueue.size(), 32'h0);
        $display("[TB] sequence complete");
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
